// File: rtl/de1_soc_qsys_sample_in.sv
// Avalon-MM input port: synchronizes an external bus, exposes it as a readable
// register, captures per-bit edges and drives a maskable level interrupt.
module de1_soc_qsys_sample_in #(
  parameter int unsigned WIDTH       = 24,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_MASK   = 2'd1,
    REG_EDGE   = 2'd2,
    REG_STATUS = 2'd3
  } reg_addr_e;

  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] rise, fall, edge_evt, clr;
  logic [2:0]       warm_q;
  logic             warm_done;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr, rd;
  reg_addr_e        addr_e;

  assign addr_e    = reg_addr_e'(address);
  assign wr        = chipselect & ~write_n;
  assign rd        = chipselect & write_n;
  assign sync_val  = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_q == WARM_MAX);
  assign readdata  = readdata_q;
  assign irq       = irq_q;

  // Upper write-data bits have no destination when the port is narrower than the bus.
  if (WIDTH < 32) begin : g_pad
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  // Synchronizer chain, previous-sample register and warm-up counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= '0;
      warm_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q <= sync_val;
      if (!warm_done) warm_q <= warm_q + 3'd1;
    end
  end

  // Edge selection (suppressed during warm-up) and next-state for mask, capture, irq, readdata.
  always_comb begin
    rise = sync_val & ~prev_q;
    fall = ~sync_val & prev_q;
    case (EDGE_TYPE)
      0:       edge_evt = rise;
      1:       edge_evt = fall;
      default: edge_evt = rise | fall;
    endcase
    if (!warm_done) edge_evt = '0;

    clr    = (wr && addr_e == REG_EDGE) ? writedata[WIDTH-1:0] : '0;
    // A new edge overrides a same-cycle clear of that bit.
    cap_d  = edge_evt | (cap_q & ~clr);
    mask_d = (wr && addr_e == REG_MASK) ? writedata[WIDTH-1:0] : mask_q;
    irq_d  = |(cap_d & mask_d);

    readdata_d = readdata_q;
    if (rd) begin
      readdata_d = '0;
      case (addr_e)
        REG_DATA:   readdata_d[WIDTH-1:0] = sync_val;
        REG_MASK:   readdata_d[WIDTH-1:0] = mask_q;
        REG_EDGE:   readdata_d[WIDTH-1:0] = cap_q;
        REG_STATUS: readdata_d[1:0]       = {warm_done, irq_q};
        default:    readdata_d            = '0;
      endcase
    end
  end

  // Register state and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      cap_q      <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

endmodule

// File: tb/tb_de1_soc_qsys_sample_in.sv
// Directed self-checking bench for de1_soc_qsys_sample_in (default parameters).
module tb_de1_soc_qsys_sample_in;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [23:0] in_port = '0;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd;

  de1_soc_qsys_sample_in #(.WIDTH(24), .SYNC_STAGES(2), .EDGE_TYPE(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    tick();
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic test_reset;
    in_port = 24'hFFFFFF;
    reset_n = 1'b0;
    #2;
    n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata: got %h want %h", readdata, 32'h0); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    tick(3);
    reset_n = 1'b1;
    tick(10);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL warm_irq: got %b want 0", irq); end
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL warm_edge: got %h want %h", rd, 32'h0); end
    bus_read(2'd3, rd);
    n_cmp++; if (rd !== 32'h2) begin n_err++; $display("FAIL warm_status: got %h want %h", rd, 32'h2); end
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h00FFFFFF) begin n_err++; $display("FAIL warm_data: got %h want %h", rd, 32'h00FFFFFF); end
  endtask

  task automatic test_rising_irq;
    in_port = 24'h000000;   // falling edges everywhere: must not be captured
    tick(5);
    bus_write(2'd1, 32'h1);
    in_port = 24'h000001;
    tick(2);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_early: got %b want 0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %b want 1", irq); end
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL edge_rise: got %h want %h", rd, 32'h1); end
    bus_write(2'd2, 32'h1);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %b want 0", irq); end
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL edge_clear: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_masked_edge;
    bus_write(2'd1, 32'h0);
    in_port = 24'h000021;
    tick(4);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL masked_irq: got %b want 0", irq); end
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h20) begin n_err++; $display("FAIL masked_edge: got %h want %h", rd, 32'h20); end
    bus_write(2'd1, 32'h20);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL unmask_irq: got %b want 1", irq); end
    bus_write(2'd2, 32'h20);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL unmask_clear: got %b want 0", irq); end
    bus_write(2'd1, 32'h0);
  endtask

  task automatic test_collision;
    in_port = 24'h000025;
    tick(2);                 // edge_evt[2] is active in the next cycle
    bus_write(2'd2, 32'h4);
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h4) begin n_err++; $display("FAIL collision_edge: got %h want %h", rd, 32'h4); end
    bus_write(2'd2, 32'h4);
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL collision_clear: got %h want %h", rd, 32'h0); end
  endtask

  task automatic test_read_width;
    in_port = 24'hA5C3F0;
    tick(4);
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h00A5C3F0) begin n_err++; $display("FAIL data_read: got %h want %h", rd, 32'h00A5C3F0); end
    tick();
    n_cmp++; if (readdata !== 32'h00A5C3F0) begin n_err++; $display("FAIL readdata_hold: got %h want %h", readdata, 32'h00A5C3F0); end
    bus_write(2'd2, 32'hFFFFFFFF);
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL edge_clear_all: got %h want %h", rd, 32'h0); end
    bus_write(2'd0, 32'hFFFFFFFF);
    bus_write(2'd3, 32'hFFFFFFFF);
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL ro_write_mask: got %h want %h", rd, 32'h0); end
    bus_read(2'd0, rd);
    n_cmp++; if (rd !== 32'h00A5C3F0) begin n_err++; $display("FAIL ro_write_data: got %h want %h", rd, 32'h00A5C3F0); end
    bus_read(2'd3, rd);
    n_cmp++; if (rd !== 32'h2) begin n_err++; $display("FAIL ro_write_status: got %h want %h", rd, 32'h2); end
    bus_write(2'd1, 32'hFFFFFFFF);
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== 32'h00FFFFFF) begin n_err++; $display("FAIL mask_width: got %h want %h", rd, 32'h00FFFFFF); end
    bus_write(2'd1, 32'h0);
  endtask

  task automatic test_mid_reset;
    bus_write(2'd1, 32'h3);
    in_port = 24'hA5C3F3;
    tick(4);
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h3) begin n_err++; $display("FAIL pre_reset_edge: got %h want %h", rd, 32'h3); end
    bus_read(2'd3, rd);
    n_cmp++; if (rd !== 32'h3) begin n_err++; $display("FAIL pre_reset_status: got %h want %h", rd, 32'h3); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL async_irq: got %b want 0", irq); end
    n_cmp++; if (readdata !== 32'h0) begin n_err++; $display("FAIL async_readdata: got %h want %h", readdata, 32'h0); end
    tick(2);
    reset_n = 1'b1;
    bus_read(2'd3, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rewarm_status: got %h want %h", rd, 32'h0); end
    tick(8);
    bus_read(2'd2, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rewarm_edge: got %h want %h", rd, 32'h0); end
    bus_read(2'd1, rd);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL rewarm_mask: got %h want %h", rd, 32'h0); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL rewarm_irq: got %b want 0", irq); end
  endtask

  initial begin
    test_reset();
    test_rising_irq();
    test_masked_edge();
    test_collision();
    test_read_width();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
